// File: rtl/axi4_lite_timer_pkg.sv
// Shared definitions for the AXI4-Lite machine timer: register offsets, response codes,
// write-channel state encoding and a byte-strobe merge helper.
package axi4_lite_timer_pkg;

    localparam logic [1:0] MTIME_LO    = 2'd0;
    localparam logic [1:0] MTIME_HI    = 2'd1;
    localparam logic [1:0] MTIMECMP_LO = 2'd2;
    localparam logic [1:0] MTIMECMP_HI = 2'd3;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        WrIdle,
        WrHaveAw,
        WrHaveW,
        WrResp
    } wr_state_e;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi4_lite_sub_ctrl.sv
// Generic AXI4-Lite subordinate handshake engine: write FSM with independent AW/W capture and a
// read holding register, presenting simple register-file strobes to the core.
module axi4_lite_sub_ctrl
    import axi4_lite_timer_pkg::*;
#(
    parameter int unsigned AddrWidth = 4,
    parameter int unsigned DataWidth = 32
) (
    input  logic                   aclk,
    input  logic                   areset_n,
    input  logic [AddrWidth-1:0]   awaddr_i,
    input  logic                   awvalid_i,
    output logic                   awready_o,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [DataWidth/8-1:0] wstrb_i,
    input  logic                   wvalid_i,
    output logic                   wready_o,
    output logic [1:0]             bresp_o,
    output logic                   bvalid_o,
    input  logic                   bready_i,
    input  logic [AddrWidth-1:0]   araddr_i,
    input  logic                   arvalid_i,
    output logic                   arready_o,
    output logic [DataWidth-1:0]   rdata_o,
    output logic [1:0]             rresp_o,
    output logic                   rvalid_o,
    input  logic                   rready_i,
    output logic                   wr_en_o,
    output logic [AddrWidth-1:0]   wr_addr_o,
    output logic [DataWidth-1:0]   wr_data_o,
    output logic [DataWidth/8-1:0] wr_strb_o,
    output logic                   rd_en_o,
    output logic [AddrWidth-1:0]   rd_addr_o,
    input  logic [DataWidth-1:0]   rd_data_i
);

    wr_state_e               state_q, state_d;
    logic [AddrWidth-1:0]    awaddr_q, awaddr_d;
    logic [DataWidth-1:0]    wdata_q, wdata_d;
    logic [DataWidth/8-1:0]  wstrb_q, wstrb_d;
    logic                    rvalid_q, rvalid_d;
    logic [DataWidth-1:0]    rdata_q, rdata_d;
    logic                    aw_hs, w_hs, ar_hs;

    // Readies are gated by reset so every handshake output reads 0 while reset is held.
    assign awready_o = areset_n && (state_q == WrIdle || state_q == WrHaveW);
    assign wready_o  = areset_n && (state_q == WrIdle || state_q == WrHaveAw);
    assign arready_o = areset_n && !rvalid_q;
    assign aw_hs     = awvalid_i && awready_o;
    assign w_hs      = wvalid_i && wready_o;
    assign ar_hs     = arvalid_i && arready_o;

    assign bvalid_o  = (state_q == WrResp);
    assign bresp_o   = RESP_OKAY;
    assign rresp_o   = RESP_OKAY;
    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;

    always_comb begin
        state_d  = state_q;
        awaddr_d = aw_hs ? awaddr_i : awaddr_q;
        wdata_d  = w_hs ? wdata_i : wdata_q;
        wstrb_d  = w_hs ? wstrb_i : wstrb_q;
        unique case (state_q)
            WrIdle: begin
                if (aw_hs && w_hs) begin
                    state_d = WrResp;
                end else if (aw_hs) begin
                    state_d = WrHaveAw;
                end else if (w_hs) begin
                    state_d = WrHaveW;
                end
            end
            WrHaveAw: if (w_hs) state_d = WrResp;
            WrHaveW:  if (aw_hs) state_d = WrResp;
            WrResp:   if (bready_i) state_d = WrIdle;
            default:  state_d = WrIdle;
        endcase
    end

    // The register write fires on the edge that completes the AW/W pair.
    assign wr_en_o   = (state_d == WrResp) && (state_q != WrResp);
    assign wr_addr_o = aw_hs ? awaddr_i : awaddr_q;
    assign wr_data_o = w_hs ? wdata_i : wdata_q;
    assign wr_strb_o = w_hs ? wstrb_i : wstrb_q;

    assign rd_en_o   = ar_hs;
    assign rd_addr_o = araddr_i;

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_data_i;
        end else if (rvalid_q && rready_i) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q  <= WrIdle;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            awaddr_q <= awaddr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: rtl/axi4_lite_timer.sv
// Memory-mapped machine timer: 64-bit mtime with prescaler, 64-bit mtimecmp and a registered
// level interrupt, behind an AXI4-Lite subordinate port.
module axi4_lite_timer
    import axi4_lite_timer_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned PRESCALE   = 1
) (
    input  logic                  aclk,
    input  logic                  areset_n,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [2:0]            awprot,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH/8-1:0]    wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [2:0]            arprot,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [WIDTH-1:0]      rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  irq
);

    localparam int unsigned PsWidth = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic                  wr_en, rd_en;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
    logic [WIDTH-1:0]      wr_data, rd_data;
    logic [WIDTH/8-1:0]    wr_strb;

    logic [63:0]           mtime_q, mtime_d;
    logic [63:0]           mtimecmp_q, mtimecmp_d;
    logic [PsWidth-1:0]    ps_q, ps_d;
    logic                  irq_q, irq_d;
    logic                  tick;

    axi4_lite_sub_ctrl #(
        .AddrWidth (ADDR_WIDTH),
        .DataWidth (WIDTH)
    ) u_sub_ctrl (
        .aclk      (aclk),
        .areset_n  (areset_n),
        .awaddr_i  (awaddr),
        .awvalid_i (awvalid),
        .awready_o (awready),
        .wdata_i   (wdata),
        .wstrb_i   (wstrb),
        .wvalid_i  (wvalid),
        .wready_o  (wready),
        .bresp_o   (bresp),
        .bvalid_o  (bvalid),
        .bready_i  (bready),
        .araddr_i  (araddr),
        .arvalid_i (arvalid),
        .arready_o (arready),
        .rdata_o   (rdata),
        .rresp_o   (rresp),
        .rvalid_o  (rvalid),
        .rready_i  (rready),
        .wr_en_o   (wr_en),
        .wr_addr_o (wr_addr),
        .wr_data_o (wr_data),
        .wr_strb_o (wr_strb),
        .rd_en_o   (rd_en),
        .rd_addr_o (rd_addr),
        .rd_data_i (rd_data)
    );

    logic unused_bits;
    assign unused_bits = ^{awprot, arprot, wr_addr[1:0], rd_addr[1:0]};

    assign tick = (ps_q == PsWidth'(PRESCALE - 1));
    assign ps_d = tick ? '0 : ps_q + 1'b1;

    // A write to either mtime half replaces that cycle's increment; the prescaler keeps counting.
    always_comb begin
        mtime_d    = mtime_q + {63'd0, tick};
        mtimecmp_d = mtimecmp_q;
        if (wr_en) begin
            unique case (wr_addr[3:2])
                MTIME_LO:    mtime_d = {mtime_q[63:32],
                                        apply_strb(mtime_q[31:0], wr_data, wr_strb)};
                MTIME_HI:    mtime_d = {apply_strb(mtime_q[63:32], wr_data, wr_strb),
                                        mtime_q[31:0]};
                MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32],
                                           apply_strb(mtimecmp_q[31:0], wr_data, wr_strb)};
                MTIMECMP_HI: mtimecmp_d = {apply_strb(mtimecmp_q[63:32], wr_data, wr_strb),
                                           mtimecmp_q[31:0]};
                default:     mtimecmp_d = mtimecmp_q;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_en) begin
            unique case (rd_addr[3:2])
                MTIME_LO:    rd_data = mtime_q[31:0];
                MTIME_HI:    rd_data = mtime_q[63:32];
                MTIMECMP_LO: rd_data = mtimecmp_q[31:0];
                MTIMECMP_HI: rd_data = mtimecmp_q[63:32];
                default:     rd_data = '0;
            endcase
        end
    end

    assign irq_d = (mtime_q >= mtimecmp_q);
    assign irq   = irq_q;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            ps_q       <= '0;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            ps_q       <= ps_d;
            irq_q      <= irq_d;
        end
    end

endmodule

// File: tb/tb_axi4_lite_timer.sv
// Self-checking bench for axi4_lite_timer: a transaction-level reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_axi4_lite_timer;

    localparam int unsigned PRESCALE = 1;

    logic        aclk, areset_n;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, irq;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    axi4_lite_timer #(
        .WIDTH      (32),
        .ADDR_WIDTH (4),
        .PRESCALE   (PRESCALE)
    ) dut (
        .aclk     (aclk),
        .areset_n (areset_n),
        .awaddr   (awaddr),
        .awprot   (awprot),
        .awvalid  (awvalid),
        .awready  (awready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .wvalid   (wvalid),
        .wready   (wready),
        .bresp    (bresp),
        .bvalid   (bvalid),
        .bready   (bready),
        .araddr   (araddr),
        .arprot   (arprot),
        .arvalid  (arvalid),
        .arready  (arready),
        .rdata    (rdata),
        .rresp    (rresp),
        .rvalid   (rvalid),
        .rready   (rready),
        .irq      (irq)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: register contents plus pending-transaction bookkeeping.
    logic [63:0] m_mtime, m_cmp;
    int unsigned m_ps;
    logic        m_irq, m_aw_held, m_w_held, m_bvalid, m_rvalid;
    logic [3:0]  m_aw_addr, m_wstrb;
    logic [31:0] m_wdata, m_rdata;

    logic        m_aw_fire, m_w_fire, m_do_wr, m_tick;
    logic [1:0]  m_wsel;
    logic [31:0] m_wd;
    logic [3:0]  m_ws;

    assign m_aw_fire = awvalid && !m_bvalid && !m_aw_held;
    assign m_w_fire  = wvalid && !m_bvalid && !m_w_held;
    assign m_do_wr   = (m_aw_fire || m_aw_held) && (m_w_fire || m_w_held);
    assign m_wsel    = m_aw_fire ? awaddr[3:2] : m_aw_addr[3:2];
    assign m_wd      = m_w_fire ? wdata : m_wdata;
    assign m_ws      = m_w_fire ? wstrb : m_wstrb;
    assign m_tick    = (m_ps == PRESCALE - 1);

    function automatic logic [31:0] m_merge(input logic [31:0] o, input logic [31:0] n,
                                            input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~mask) | (n & mask);
    endfunction

    function automatic logic [31:0] m_reg(input logic [1:0] sel);
        logic [127:0] regs;
        regs = {m_cmp, m_mtime};
        return regs[32*sel +: 32];
    endfunction

    always @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            m_mtime   <= 64'd0;
            m_cmp     <= {64{1'b1}};
            m_ps      <= 0;
            m_irq     <= 1'b0;
            m_aw_held <= 1'b0;
            m_w_held  <= 1'b0;
            m_bvalid  <= 1'b0;
            m_rvalid  <= 1'b0;
            m_rdata   <= 32'd0;
        end else begin
            m_irq <= (m_mtime >= m_cmp);
            m_ps  <= m_tick ? 0 : m_ps + 1;
            if (m_do_wr && m_wsel == 2'd0)
                m_mtime <= {m_mtime[63:32], m_merge(m_mtime[31:0], m_wd, m_ws)};
            else if (m_do_wr && m_wsel == 2'd1)
                m_mtime <= {m_merge(m_mtime[63:32], m_wd, m_ws), m_mtime[31:0]};
            else
                m_mtime <= m_mtime + (m_tick ? 64'd1 : 64'd0);
            if (m_do_wr && m_wsel == 2'd2)
                m_cmp <= {m_cmp[63:32], m_merge(m_cmp[31:0], m_wd, m_ws)};
            else if (m_do_wr && m_wsel == 2'd3)
                m_cmp <= {m_merge(m_cmp[63:32], m_wd, m_ws), m_cmp[31:0]};
            if (m_do_wr) begin
                m_aw_held <= 1'b0;
                m_w_held  <= 1'b0;
                m_bvalid  <= 1'b1;
            end else begin
                if (m_bvalid && bready) m_bvalid <= 1'b0;
                if (m_aw_fire) begin
                    m_aw_held <= 1'b1;
                    m_aw_addr <= awaddr;
                end
                if (m_w_fire) begin
                    m_w_held <= 1'b1;
                    m_wdata  <= wdata;
                    m_wstrb  <= wstrb;
                end
            end
            if (m_rvalid) begin
                if (rready) m_rvalid <= 1'b0;
            end else if (arvalid) begin
                m_rvalid <= 1'b1;
                m_rdata  <= m_reg(araddr[3:2]);
            end
        end
    end

    always @(negedge aclk) begin
        if (areset_n) begin
            chk("awready", awready, !m_bvalid && !m_aw_held);
            chk("wready", wready, !m_bvalid && !m_w_held);
            chk("bvalid", bvalid, m_bvalid);
            chk("bresp", bresp, 2'b00);
            chk("arready", arready, !m_rvalid);
            chk("rvalid", rvalid, m_rvalid);
            chk("rresp", rresp, 2'b00);
            chk("rdata", rdata, m_rdata);
            chk("irq", irq, m_irq);
        end
    end

    // Tasks start and end on a falling clock edge.
    task automatic axi_read(input logic [3:0] a, input int stall, output logic [31:0] d);
        int n;
        araddr  = a;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        @(negedge aclk);
        arvalid = 1'b0;
        while (!rvalid && n < 50) begin
            @(negedge aclk);
            n++;
        end
        chk("rd_handshake_in_time", n < 50, 1'b1);
        d = rdata;
        for (int i = 0; i < stall; i++) begin
            chk("stall_rvalid", rvalid, 1'b1);
            chk("stall_arready", arready, 1'b0);
            @(negedge aclk);
        end
        rready = 1'b1;
        @(negedge aclk);
        rready = 1'b0;
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly);
        int cyc;
        bit aw_done, w_done, aw_f, w_f;
        cyc = 0;
        aw_done = 1'b0;
        w_done  = 1'b0;
        awaddr = a;
        wdata  = d;
        wstrb  = s;
        while (!(aw_done && w_done) && cyc < 50) begin
            awvalid = !aw_done && cyc >= aw_dly;
            wvalid  = !w_done && cyc >= w_dly;
            if (aw_done && !w_done) chk("awready_while_waiting_w", awready, 1'b0);
            if (w_done && !aw_done) chk("wready_while_waiting_aw", wready, 1'b0);
            aw_f = awvalid && awready;
            w_f  = wvalid && wready;
            @(negedge aclk);
            aw_done |= aw_f;
            w_done  |= w_f;
            cyc++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        while (!bvalid && cyc < 50) begin
            @(negedge aclk);
            cyc++;
        end
        chk("wr_handshake_in_time", cyc < 50, 1'b1);
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        chk("bvalid_single_beat", bvalid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] v, v2;
        awaddr = 4'd0; araddr = 4'd0; awprot = 3'd0; arprot = 3'd0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        wdata = 32'd0; wstrb = 4'd0;
        areset_n = 1'b1;
        #1 areset_n = 1'b0;
        #1;
        chk("rst_awready", awready, 1'b0);
        chk("rst_wready", wready, 1'b0);
        chk("rst_arready", arready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_irq", irq, 1'b0);
        repeat (2) @(posedge aclk);
        #1 areset_n = 1'b1;

        // Free-running count after reset.
        @(negedge aclk);
        repeat (9) @(negedge aclk);
        axi_read(4'h0, 0, v);
        chk("mtime_after_10_in_range", (v >= 32'd9 && v <= 32'd11), 1'b1);
        axi_read(4'h8, 0, v);
        chk("mtimecmp_lo_reset", v, 32'hFFFF_FFFF);
        axi_read(4'hC, 0, v);
        chk("mtimecmp_hi_reset", v, 32'hFFFF_FFFF);

        // Single-byte strobe into mtimecmp_lo.
        axi_write(4'h8, 32'hAABB_CCDD, 4'b0010, 0, 0);
        axi_read(4'h8, 0, v);
        chk("strobe_byte1", v, 32'hFFFF_CCFF);

        // AW leads W by three cycles.
        axi_write(4'h0, 32'h0000_0100, 4'hF, 0, 3);
        axi_read(4'h0, 0, v);
        chk("mtime_ge_0x100", v >= 32'h100, 1'b1);
        axi_read(4'h0, 0, v2);
        chk("mtime_increasing", v2 > v, 1'b1);

        // Carry from the low into the high half.
        axi_write(4'h4, 32'h0, 4'hF, 0, 0);
        axi_write(4'h0, 32'hFFFF_FFFE, 4'hF, 0, 0);
        repeat (2) @(negedge aclk);
        axi_read(4'h4, 0, v);
        chk("carry_into_hi", v, 32'h1);

        // Compare match: W leads AW for the high half.
        axi_write(4'hC, 32'h0, 4'hF, 2, 0);
        axi_write(4'h8, 32'h40, 4'hF, 0, 0);
        axi_write(4'h4, 32'h0, 4'hF, 0, 0);
        axi_write(4'h0, 32'h3C, 4'hF, 1, 1);
        chk("irq_low_edge1", irq, 1'b0);
        repeat (3) begin
            @(negedge aclk);
            chk("irq_low_before_match", irq, 1'b0);
        end
        @(negedge aclk);
        chk("irq_rises_edge5", irq, 1'b1);
        repeat (2) @(negedge aclk);
        chk("irq_stays_high", irq, 1'b1);
        axi_write(4'h8, 32'h1000, 4'hF, 0, 0);
        chk("irq_falls_after_cmp_raise", irq, 1'b0);

        // Read held while the master stalls rready.
        axi_read(4'h8, 5, v);
        chk("stalled_read_value", v, 32'h1000);

        // Reset asserted while a write response and read data are both outstanding.
        araddr = 4'hC; arvalid = 1'b1;
        awaddr = 4'h0; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge aclk);
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        chk("resp_pending_bvalid", bvalid, 1'b1);
        chk("resp_pending_rvalid", rvalid, 1'b1);
        #2 areset_n = 1'b0;
        #1;
        chk("midrst_bvalid", bvalid, 1'b0);
        chk("midrst_rvalid", rvalid, 1'b0);
        chk("midrst_irq", irq, 1'b0);
        chk("midrst_rdata", rdata, 32'd0);
        repeat (2) @(posedge aclk);
        #1 areset_n = 1'b1;
        @(negedge aclk);
        axi_read(4'h0, 0, v);
        chk("mtime_zero_after_reset", v, 32'd0);
        axi_read(4'h8, 0, v);
        chk("mtimecmp_restored", v, 32'hFFFF_FFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi4_lite_timer.md
Name: axi4_lite_timer

Overview:
- Memory-mapped machine timer: free-running 64-bit mtime counter, 64-bit mtimecmp compare register, level interrupt output.
- Sits directly downstream of the 4-port AXI4-Lite crossbar as one subordinate, occupying one 16-byte window (ADDR_WIDTH 4).
- Accepts single-beat AXI4-Lite reads and writes with full independent channel handshakes.

Parameters:
- WIDTH, 32, data bus width; only 32 supported.
- ADDR_WIDTH, 4, subordinate address width; bits [3:2] select the register, [1:0] ignored.
- PRESCALE, 1, clock cycles per mtime increment; must be ≥1.

Ports:
- aclk  in  1  clock.
- areset_n  in  1  asynchronous active-low reset.
- awaddr  in  ADDR_WIDTH  write address.
- awprot  in  3  ignored.
- awvalid / awready  in / out  1  AW handshake.
- wdata  in  WIDTH  write data.
- wstrb  in  WIDTH/8  byte strobes.
- wvalid / wready  in / out  1  W handshake.
- bresp  out  2  write response, always OKAY (2'b00).
- bvalid / bready  out / in  1  B handshake.
- araddr  in  ADDR_WIDTH  read address.
- arprot  in  3  ignored.
- arvalid / arready  in / out  1  AR handshake.
- rdata  out  WIDTH  read data.
- rresp  out  2  always OKAY.
- rvalid / rready  out / in  1  R handshake.
- irq  out  1  timer interrupt, registered.

Behaviour:
- Register map: 0x0 mtime[31:0], 0x4 mtime[63:32], 0x8 mtimecmp[31:0], 0xC mtimecmp[63:32].
- Reset (async, areset_n low):
  - mtime=0, mtimecmp=all ones, prescale count=0.
  - All ready/valid outputs 0; rdata=0; bresp=rresp=0; irq=0.
  - Any in-flight transaction is dropped.
- Prescaler: counts 0..PRESCALE-1. mtime increments by 1 on the cycle the count wraps. With PRESCALE=1, mtime increments every cycle. 64-bit wrap from all ones to 0.
- Write channel states: IDLE, HAVE_AW, HAVE_W, RESP.
  - awready=1 in IDLE and HAVE_W. wready=1 in IDLE and HAVE_AW.
  - AW and W are accepted in either order or in the same cycle. Address and data/strobes are latched on acceptance.
  - Once both are held: the register is written at that clock edge (same-cycle acceptance) or at the edge completing the pair, honoring wstrb per byte. State then moves to RESP.
  - RESP: bvalid=1 until bready; then IDLE. No new AW/W is accepted while in RESP.
  - A write to either mtime half suppresses that cycle's increment (written value wins). The prescale count is not reset.
- Read channel:
  - arready=1 whenever rvalid=0.
  - On AR handshake, rdata is loaded at that edge with the register value (pre-increment, pre-write of that edge), and rvalid rises next cycle.
  - rdata/rvalid are held stable until rready; arready stays 0 meanwhile.
  - Read and write channels operate concurrently.
- irq: registered each cycle as (mtime >= mtimecmp), unsigned 64-bit, one cycle after the compare becomes true. It stays asserted until mtimecmp is raised or mtime is rewritten.

Decomposition:
- Package axi4_lite_timer_pkg: register offset constants (MTIME_LO/HI, MTIMECMP_LO/HI), RESP_OKAY constant, write-FSM state enum.
- One sub-module: axi4_lite_sub_ctrl, the generic AXI4-Lite subordinate handshake engine. It implements the write FSM and read holding register and exposes wr_en/wr_addr/wr_data/wr_strb and rd_en/rd_addr/rd_data to the register core. It is reused by future subordinates.

Test Plan:
- Reset then read 0x8 and 0xC -> rdata 0xFFFF_FFFF both, rresp 0, irq 0. Read 0x0 after 10 cycles (PRESCALE=1) -> value in 9..11 consistent with AR edge.
- AW to 0x0 issued, W (0x0000_0100, wstrb 0xF) 3 cycles later -> awready low during wait, single bvalid after W. Read 0x0 -> ≥0x100 and increasing.
- Write mtime_lo=0xFFFF_FFFE, mtime_hi=0 -> within 3 cycles read 0x4 = 0x1. Carry across halves verified.
- mtimecmp_hi=0, mtimecmp_lo=0x40, mtime=0x3C -> irq rises exactly 5 cycles after mtime write (4 increments + 1 register). Writing mtimecmp_lo=0x1000 -> irq falls 1 cycle later.
- wstrb=0b0010, wdata=0xAABB_CCDD to 0x8 from reset value -> mtimecmp_lo=0xFFFF_CCFF.
- rready held low 5 cycles -> rdata/rvalid stable, arready 0. Assert areset_n low mid-RESP -> bvalid, rvalid 0 immediately, mtime 0.
